// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO with drop indication
module sync_fifo #(
    parameter int Width     = 8,
    parameter int DepthLog2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int Depth = 1 << DepthLog2;

    logic [Width-1:0]     mem [Depth];
    logic [DepthLog2-1:0] wr_ptr;
    logic [DepthLog2-1:0] rd_ptr;
    logic [DepthLog2:0]   count;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (count == '0);
    assign full  = (count == (DepthLog2 + 1)'(Depth));

    // A pop from a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + DepthLog2'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + DepthLog2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (DepthLog2 + 1)'(1);
                2'b01:   count <= count - (DepthLog2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a byte FIFO with sticky error flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FPGAClkSpeed  = 50000000,
    parameter int BaudRate6502  = 230400,
    parameter int FifoDepthLog2 = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       uart_rx_i,
    input  logic       rd_en_i,
    output logic [7:0] rd_data_o,
    output logic       empty_o,
    output logic       full_o,
    input  logic       clr_flags_i,
    output logic       overflow_o,
    output logic       frame_err_o
);

    localparam int ClksPerBit = clks_per_bit(FPGAClkSpeed, BaudRate6502);
    localparam int HalfBit    = ClksPerBit / 2;
    localparam int CntW       = $clog2(ClksPerBit) + 1;

    localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(HalfBit - 1);

    logic            sync_1;
    logic            line_s;
    logic [1:0]      settle;
    logic            armed;

    rx_state_t       state;
    rx_state_t       state_next;
    logic [CntW-1:0] cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            push_r;

    logic            half_tick;
    logic            bit_tick;
    logic            cnt_clr;
    logic            shift_en;
    logic            stop_ok;
    logic            stop_bad;
    logic            fifo_drop;

    // The line only counts as idle once the synchronizer has refilled with real
    // samples after reset; a line still low from an abandoned frame never arms.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_1 <= 1'b1;
            line_s <= 1'b1;
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sync_1 <= uart_rx_i;
            line_s <= sync_1;
            settle <= {settle[0], 1'b1};
            armed  <= armed | (settle[1] & line_s);
        end
    end

    assign half_tick = (cnt == HalfEnd);
    assign bit_tick  = (cnt == BitEnd);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (armed && !line_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (half_tick) begin
                    state_next = line_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick && bit_idx == 3'd7) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_next = line_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (line_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state)
            IDLE:      cnt_clr = 1'b1;
            START:     cnt_clr = half_tick;
            DATA: begin
                cnt_clr  = bit_tick;
                shift_en = bit_tick;
            end
            STOP: begin
                cnt_clr  = bit_tick;
                stop_ok  = bit_tick & line_s;
                stop_bad = bit_tick & ~line_s;
            end
            WAIT_IDLE: cnt_clr = 1'b1;
            default:   cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            push_r  <= 1'b0;
        end else begin
            cnt    <= cnt_clr ? '0 : cnt + CntW'(1);
            push_r <= stop_ok;
            if (state == START) begin
                bit_idx <= '0;
            end
            if (shift_en) begin
                shreg   <= {line_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    sync_fifo #(
        .Width    (8),
        .DepthLog2(FifoDepthLog2)
    ) u_fifo (
        .clk      (clk_i),
        .reset    (reset_i),
        .push     (push_r),
        .push_data(shreg),
        .pop      (rd_en_i),
        .pop_data (rd_data_o),
        .empty    (empty_o),
        .full     (full_o),
        .drop     (fifo_drop)
    );

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (fifo_drop) begin
                overflow_o <= 1'b1;
            end else if (clr_flags_i) begin
                overflow_o <= 1'b0;
            end
            if (stop_bad) begin
                frame_err_o <= 1'b1;
            end else if (clr_flags_i) begin
                frame_err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo at default parameters
module tb_uart_rx_fifo;

    localparam int Cpb = 50000000 / 230400;

    logic       clk_i       = 1'b0;
    logic       reset_i     = 1'b1;
    logic       uart_rx_i   = 1'b1;
    logic       rd_en_i     = 1'b0;
    logic       clr_flags_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       empty_o;
    logic       full_o;
    logic       overflow_o;
    logic       frame_err_o;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic       mon_en = 1'b0;

    always #5 clk_i = ~clk_i;

    uart_rx_fifo dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .uart_rx_i  (uart_rx_i),
        .rd_en_i    (rd_en_i),
        .rd_data_o  (rd_data_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .clr_flags_i(clr_flags_i),
        .overflow_o (overflow_o),
        .frame_err_o(frame_err_o)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_empty"}, {7'd0, empty_o}, 8'h01);
        check({tag, "_full"}, {7'd0, full_o}, 8'h00);
        check({tag, "_overflow"}, {7'd0, overflow_o}, 8'h00);
        check({tag, "_frame_err"}, {7'd0, frame_err_o}, 8'h00);
        check({tag, "_rd_data"}, rd_data_o, 8'h00);
    endtask

    task automatic bit_time(input logic v);
        uart_rx_i = v;
        repeat (Cpb) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) begin
            bit_time(b[i]);
        end
        bit_time(stop);
        bit_time(1'b1);
    endtask

    task automatic pulse_clr();
        clr_flags_i = 1'b1;
        @(negedge clk_i);
        clr_flags_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_bytes_pending required=0", name, exp_q.size());
        end
        repeat (3) @(negedge clk_i);
    endtask

    // Monitor: pops every byte the DUT presents and compares against the scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            rd_en_i = 1'b0;
            if (mon_en && !empty_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%02h required=none", rd_data_o);
                end else begin
                    check("rx_byte", rd_data_o, exp_q.pop_front());
                end
                rd_en_i = 1'b1;
            end
        end
    end

    initial begin
        repeat (90000) @(negedge clk_i);
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk_i);
        check_reset_outputs("reset");
        reset_i = 1'b0;
        repeat (5) @(negedge clk_i);

        mon_en = 1'b1;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        wait_drain("a5");
        check("a5_overflow", {7'd0, overflow_o}, 8'h00);
        check("a5_frame_err", {7'd0, frame_err_o}, 8'h00);

        mon_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_byte(8'(i), 1'b1);
        end
        check("fill_full", {7'd0, full_o}, 8'h01);
        check("fill_overflow", {7'd0, overflow_o}, 8'h01);
        check("fill_head", rd_data_o, 8'h00);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
        end
        mon_en = 1'b1;
        wait_drain("fill");
        check("fill_empty_after", {7'd0, empty_o}, 8'h01);
        check("fill_full_after", {7'd0, full_o}, 8'h00);
        pulse_clr();
        check("fill_overflow_clr", {7'd0, overflow_o}, 8'h00);

        send_byte(8'h3C, 1'b0);
        check("ferr_set", {7'd0, frame_err_o}, 8'h01);
        check("ferr_empty", {7'd0, empty_o}, 8'h01);
        pulse_clr();
        check("ferr_clr", {7'd0, frame_err_o}, 8'h00);

        uart_rx_i = 1'b0;
        repeat (50) @(negedge clk_i);
        uart_rx_i = 1'b1;
        repeat (2 * Cpb) @(negedge clk_i);
        check("glitch_empty", {7'd0, empty_o}, 8'h01);
        check("glitch_frame_err", {7'd0, frame_err_o}, 8'h00);

        for (int i = 0; i < 15; i++) bit_time(1'b0);
        check("break_ferr_set", {7'd0, frame_err_o}, 8'h01);
        pulse_clr();
        for (int i = 0; i < 15; i++) bit_time(1'b0);
        check("break_ferr_once", {7'd0, frame_err_o}, 8'h00);
        bit_time(1'b1);
        bit_time(1'b1);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        wait_drain("after_break");
        check("after_break_ferr", {7'd0, frame_err_o}, 8'h00);

        mon_en = 1'b0;
        send_byte(8'h22, 1'b1);
        send_byte(8'h3C, 1'b0);
        check("pre_reset_nonempty", {7'd0, empty_o}, 8'h00);
        check("pre_reset_ferr", {7'd0, frame_err_o}, 8'h01);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b0);
        repeat (Cpb / 2) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("mid_reset");
        repeat (5) @(negedge clk_i);
        reset_i = 1'b0;
        mon_en  = 1'b1;
        repeat (Cpb - Cpb / 2 - 6) @(negedge clk_i);
        for (int i = 0; i < 3; i++) bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        bit_time(1'b1);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        wait_drain("post_reset");
        check("post_reset_empty", {7'd0, empty_o}, 8'h01);
        check("post_reset_ferr", {7'd0, frame_err_o}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter FPGAClkSpeed, default 50000000, meaning clk_i frequency in Hz.
REQ-002 SHALL have parameter BaudRate6502, default 230400, meaning serial bit rate.
REQ-003 SHALL have parameter FifoDepthLog2, default 4, meaning log2 of receive FIFO depth (16 bytes).
REQ-004 SHALL have port clk_i, input, 1, meaning the single system clock.
REQ-005 SHALL have port reset_i, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port uart_rx_i, input, 1, meaning asynchronous serial line, idle high.
REQ-007 SHALL have port rd_en_i, input, 1, meaning pop one byte from the FIFO.
REQ-008 SHALL have port rd_data_o, output, 8, meaning FIFO head byte (first-word fall-through).
REQ-009 SHALL have port empty_o, output, 1, meaning FIFO holds no bytes.
REQ-010 SHALL have port full_o, output, 1, meaning FIFO holds 2**FifoDepthLog2 bytes.
REQ-011 SHALL have port clr_flags_i, input, 1, meaning clear sticky error flags.
REQ-012 SHALL have port overflow_o, output, 1, meaning sticky: a byte was dropped because the FIFO was full.
REQ-013 SHALL have port frame_err_o, output, 1, meaning sticky: a stop bit sampled low.

Function
REQ-014 SHALL pass uart_rx_i through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal.
REQ-015 SHALL use ClksPerBit = FPGAClkSpeed / BaudRate6502 (integer division; 217 at defaults) and HalfBit = ClksPerBit / 2.
REQ-016 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-017 IDLE: on synchronized line low, load baud counter, go to START.
REQ-018 START: after HalfBit clocks sample the line; low -> go to DATA with bit index 0; high -> glitch, return to IDLE with no flag.
REQ-019 DATA: sample every ClksPerBit clocks, LSB first, into a shift register; after bit 7 go to STOP.
REQ-020 STOP: after ClksPerBit clocks sample; high -> push byte on the next cycle and go to IDLE; low -> set frame_err_o, discard byte, go to WAIT_IDLE.
REQ-021 WAIT_IDLE: remain until the line is sampled high, then go to IDLE; a held-low break SHALL set frame_err_o once only.
REQ-022 Byte push SHALL make empty_o fall one cycle after the push cycle; rd_data_o SHALL be valid whenever empty_o is low.
REQ-023 rd_en_i with empty_o high SHALL be ignored; no state changes.
REQ-024 Push with full_o high and no simultaneous pop SHALL drop the byte and set overflow_o; FIFO contents are unchanged.
REQ-025 Push and pop in the same cycle SHALL both take effect (count unchanged), including when full.
REQ-026 FIFO pointers SHALL wrap modulo 2**FifoDepthLog2; occupancy count SHALL be FifoDepthLog2+1 bits wide.
REQ-027 clr_flags_i SHALL clear both sticky flags next cycle; a set event in the same cycle SHALL win.

Reset
REQ-028 While reset_i is high at a clock edge: state IDLE, counters 0, FIFO emptied, empty_o=1, full_o=0, overflow_o=0, frame_err_o=0, rd_data_o=0, synchronizer flops=1.
REQ-029 Reset mid-frame SHALL abandon the partial byte; after reset the receiver SHALL rearm only on a fresh falling edge.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum type and a function computing ClksPerBit from clock and baud.
REQ-031 The FIFO SHALL be a sub-module sync_fifo (parameters width and depth-log2; ports push, pop, data, empty, full).
REQ-032 The baud counter width SHALL be $clog2(ClksPerBit)+1.

Verification
REQ-033 Send 0xA5 with stop=1 at defaults -> empty_o falls; rd_data_o=0xA5; no flags set.
REQ-034 Send 17 bytes 0x00..0x10 with no reads (depth 16) -> full_o=1, overflow_o=1, reads return 0x00..0x0F, then empty_o=1.
REQ-035 Send 0x3C with stop bit low -> no push, frame_err_o=1; pulse clr_flags_i -> frame_err_o=0.
REQ-036 Apply a 50-clock low glitch on idle line -> no push, no flags, state returns to IDLE.
REQ-037 Hold the line low for 30 bit times, then send 0x81 -> frame_err_o set exactly once, 0x81 received correctly.
REQ-038 Assert reset_i during bit 4 of a frame, then send 0x5A -> only 0x5A in the FIFO; outputs at reset values during reset.
